// File: rtl/frequency_divider_prog_pkg.sv
// Shared definitions for the programmable multi-channel frequency divider.
package fd_pkg;

  localparam int FD_CW_DEF  = 16;
  localparam int FD_DIV_DEF = 50;

  // Channel-select width; a single channel still needs a one-bit select.
  function automatic int fd_chw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Per-channel state record at the default counter width.
  typedef struct packed {
    logic [FD_CW_DEF-1:0] cnt;
    logic [FD_CW_DEF-1:0] div;
    logic                 casc;
    logic [FD_CW_DEF-1:0] shadow;
    logic                 shcasc;
    logic                 pend;
  } fd_ch_state_t;

endpackage

// File: rtl/frequency_divider_prog_if.sv
// Ratio write bus: one-cycle strobe with registered accept/reject pulses.
interface frequency_divider_prog_if #(
  parameter int N_CH = 4,
  parameter int CW   = fd_pkg::FD_CW_DEF,
  parameter int CHW  = fd_pkg::fd_chw(N_CH)
);
  logic           WR_EN;
  logic [CHW-1:0] WR_CH;
  logic [CW-1:0]  WR_DIV;
  logic           WR_CASC;
  logic           WR_ACK;
  logic           WR_ERR;

  modport master (output WR_EN, WR_CH, WR_DIV, WR_CASC, input WR_ACK, WR_ERR);
  modport slave  (input WR_EN, WR_CH, WR_DIV, WR_CASC, output WR_ACK, WR_ERR);
endinterface

// File: rtl/frequency_divider_prog_channel.sv
// One divider channel: wrap counter, shadowed ratio reload, TICK and SQW registers.
module fd_channel import fd_pkg::*; #(
  parameter int          CW       = FD_CW_DEF,
  parameter logic [CW-1:0] DEF_DIV = CW'(FD_DIV_DEF),
  parameter bit          DEF_CASC = 1'b0
) (
  input  logic          CP,
  input  logic          nCR,
  input  logic          i_adv,
  input  logic          i_ld,
  input  logic [CW-1:0] i_ld_div,
  input  logic          i_ld_casc,
  input  logic          i_sync,
  output logic          o_tick,
  output logic          o_sqw,
  output logic          o_pend,
  output logic          o_casc
);
  logic [CW-1:0] r_cnt, r_div, r_shadow;
  logic          r_casc, r_shcasc, r_pend, r_tick, r_sqw;
  logic          w_term;
  logic [CW-1:0] w_cnt_nxt, w_hi;

  // >= rather than == so the wrap is still found if the count ever exceeds the ratio.
  assign w_term    = i_adv & (r_cnt >= (r_div - CW'(1)));
  assign w_cnt_nxt = w_term ? '0 : (r_cnt + CW'(1));
  assign w_hi      = r_div - (r_div >> 1);

  // Counter, reload and output registers; SYNC overrides counting for one cycle.
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      r_cnt    <= '0;
      r_div    <= DEF_DIV;
      r_casc   <= DEF_CASC;
      r_shadow <= DEF_DIV;
      r_shcasc <= DEF_CASC;
      r_pend   <= 1'b0;
      r_tick   <= 1'b0;
      r_sqw    <= 1'b0;
    end else if (i_sync) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
      r_sqw  <= 1'b0;
      r_pend <= 1'b0;
      if (i_ld) begin
        r_div    <= i_ld_div;
        r_casc   <= i_ld_casc;
        r_shadow <= i_ld_div;
        r_shcasc <= i_ld_casc;
      end else if (r_pend) begin
        r_div  <= r_shadow;
        r_casc <= r_shcasc;
      end
    end else begin
      r_tick <= w_term;
      if (i_adv) begin
        r_cnt <= w_cnt_nxt;
        r_sqw <= (w_cnt_nxt < w_hi);
      end
      if (i_ld) begin
        r_shadow <= i_ld_div;
        r_shcasc <= i_ld_casc;
        if (w_term) begin
          r_div  <= i_ld_div;
          r_casc <= i_ld_casc;
          r_pend <= 1'b0;
        end else begin
          r_pend <= 1'b1;
        end
      end else if (w_term && r_pend) begin
        r_div  <= r_shadow;
        r_casc <= r_shcasc;
        r_pend <= 1'b0;
      end
    end
  end

  assign o_tick = r_tick;
  assign o_sqw  = r_sqw;
  assign o_pend = r_pend;
  assign o_casc = r_casc;
endmodule

// File: rtl/frequency_divider_prog.sv
// Programmable multi-channel divider: write decode, handshake pulses and cascade wiring.
module frequency_divider_prog import fd_pkg::*; #(
  parameter int              N_CH     = 4,
  parameter int              CW       = FD_CW_DEF,
  parameter int              DEF_DIV  = FD_DIV_DEF,
  parameter logic [N_CH-1:0] DEF_CASC = '0
) (
  input  logic                     CP,
  input  logic                     nCR,
  input  logic                     CE,
  input  logic                     SYNC,
  frequency_divider_prog_if.slave  bus,
  output logic [N_CH-1:0]          PEND,
  output logic [N_CH-1:0]          TICK,
  output logic [N_CH-1:0]          SQW
);
  localparam int CHW = fd_chw(N_CH);

  logic            w_wr_ok;
  logic [N_CH-1:0] w_adv, w_casc, w_parent;
  logic            r_ack, r_err;

  assign w_wr_ok = bus.WR_EN & (bus.WR_DIV != '0) & (32'(bus.WR_CH) < 32'(N_CH));

  // Accept/reject pulses are decided in the strobe cycle and shown one cycle later.
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_ack <= w_wr_ok;
      r_err <= bus.WR_EN & ~w_wr_ok;
    end
  end

  assign bus.WR_ACK = r_ack;
  assign bus.WR_ERR = r_err;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic w_ld, w_ld_casc;

    assign w_ld = w_wr_ok & (bus.WR_CH == CHW'(g));

    // Channel 0 has no parent, so its cascade select is pinned low.
    if (g == 0) begin : g_root
      assign w_parent[g] = 1'b0;
      assign w_ld_casc   = 1'b0;
    end else begin : g_casc
      assign w_parent[g] = TICK[g-1];
      assign w_ld_casc   = bus.WR_CASC;
    end

    assign w_adv[g] = CE & (w_casc[g] ? w_parent[g] : 1'b1);

    fd_channel #(
      .CW       (CW),
      .DEF_DIV  (CW'(DEF_DIV)),
      .DEF_CASC ((g == 0) ? 1'b0 : DEF_CASC[g])
    ) u_ch (
      .CP        (CP),
      .nCR       (nCR),
      .i_adv     (w_adv[g]),
      .i_ld      (w_ld),
      .i_ld_div  (bus.WR_DIV),
      .i_ld_casc (w_ld_casc),
      .i_sync    (SYNC),
      .o_tick    (TICK[g]),
      .o_sqw     (SQW[g]),
      .o_pend    (PEND[g]),
      .o_casc    (w_casc[g])
    );
  end
endmodule

// File: tb/tb_frequency_divider_prog.sv
// Bench for frequency_divider_prog: per-cycle model compare plus directed period/phase checks.
module tb_frequency_divider_prog;
  localparam int N = 4;

  logic         CP = 1'b0;
  logic         nCR, CE, SYNC;
  logic [N-1:0] PEND, TICK, SQW;
  logic [2:0]   PEND3, TICK3, SQW3;

  int n_checks = 0;
  int n_errors = 0;

  frequency_divider_prog_if #(.N_CH(N), .CW(16)) bus ();
  frequency_divider_prog_if #(.N_CH(3), .CW(16)) bus3 ();

  frequency_divider_prog #(.N_CH(N), .CW(16), .DEF_DIV(50), .DEF_CASC(4'b0000)) dut (
    .CP(CP), .nCR(nCR), .CE(CE), .SYNC(SYNC), .bus(bus),
    .PEND(PEND), .TICK(TICK), .SQW(SQW));

  frequency_divider_prog #(.N_CH(3), .CW(16), .DEF_DIV(50), .DEF_CASC(3'b000)) dut3 (
    .CP(CP), .nCR(nCR), .CE(1'b1), .SYNC(1'b0), .bus(bus3),
    .PEND(PEND3), .TICK(TICK3), .SQW(SQW3));

  always #5 CP = ~CP;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each channel is tracked as "advances completed in the current period".
  int  m_pos [N];
  int  m_div [N];
  int  m_sh  [N];
  bit  m_casc[N], m_shc[N], m_pend[N], m_tick[N], m_sqw[N];
  bit  m_ack, m_err, m_valid = 1'b0;

  // Model state update, evaluated from the inputs present at each rising edge.
  always @(posedge CP or negedge nCR) begin
    bit ok, hit, adv, wrap, wc, parent;
    bit prev[N];
    int wdiv;
    if (!nCR) begin
      for (int i = 0; i < N; i++) begin
        m_pos[i] = 0; m_div[i] = 50; m_sh[i] = 50;
        m_casc[i] = 0; m_shc[i] = 0; m_pend[i] = 0; m_tick[i] = 0; m_sqw[i] = 0;
      end
      m_ack = 0; m_err = 0; m_valid = 1;
    end else begin
      ok    = bus.WR_EN && (bus.WR_DIV != 0) && (int'(bus.WR_CH) < N);
      m_ack = ok;
      m_err = bus.WR_EN && !ok;
      prev  = m_tick;
      wdiv  = int'(bus.WR_DIV);
      for (int i = 0; i < N; i++) begin
        hit = ok && (int'(bus.WR_CH) == i);
        wc  = (i == 0) ? 1'b0 : bus.WR_CASC;
        if (SYNC) begin
          m_pos[i] = 0; m_tick[i] = 0; m_sqw[i] = 0;
          if (hit) begin
            m_div[i] = wdiv; m_casc[i] = wc; m_sh[i] = wdiv; m_shc[i] = wc;
          end else if (m_pend[i]) begin
            m_div[i] = m_sh[i]; m_casc[i] = m_shc[i];
          end
          m_pend[i] = 0;
        end else begin
          parent = (i > 0) ? prev[i-1] : 1'b0;
          adv    = CE && (!m_casc[i] || parent);
          wrap   = adv && (m_pos[i] + 1 >= m_div[i]);
          m_tick[i] = wrap;
          if (adv) begin
            m_pos[i] = wrap ? 0 : m_pos[i] + 1;
            m_sqw[i] = (m_pos[i] < (m_div[i] + 1) / 2);
          end
          if (hit) begin
            m_sh[i] = wdiv; m_shc[i] = wc;
            if (wrap) begin
              m_div[i] = wdiv; m_casc[i] = wc; m_pend[i] = 0;
            end else begin
              m_pend[i] = 1;
            end
          end else if (wrap && m_pend[i]) begin
            m_div[i] = m_sh[i]; m_casc[i] = m_shc[i]; m_pend[i] = 0;
          end
        end
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model, on the falling edge.
  always @(negedge CP) begin
    logic [N-1:0] et, es, ep;
    if (m_valid) begin
      for (int i = 0; i < N; i++) begin
        et[i] = m_tick[i]; es[i] = m_sqw[i]; ep[i] = m_pend[i];
      end
      chk("model_tick", 32'(TICK), 32'(et));
      chk("model_sqw",  32'(SQW),  32'(es));
      chk("model_pend", 32'(PEND), 32'(ep));
      chk("model_ack",  32'(bus.WR_ACK), 32'(m_ack));
      chk("model_err",  32'(bus.WR_ERR), 32'(m_err));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wr(input int ch, input int dv, input bit cs);
    bus.WR_EN = 1'b1; bus.WR_CH = 2'(ch); bus.WR_DIV = 16'(dv); bus.WR_CASC = cs;
  endtask

  task automatic idle();
    bus.WR_EN = 1'b0; bus.WR_CASC = 1'b0; bus.WR_DIV = '0; bus.WR_CH = '0;
  endtask

  task automatic wait_tick(input int ch, input int budget, output int n);
    n = 0;
    do begin
      @(negedge CP);
      n++;
    end while (!TICK[ch] && n < budget);
    if (!TICK[ch]) begin
      n_checks++;
      n_errors++;
      $display("FAIL tick_timeout: ch%0d got no TICK, required one within %0d cycles", ch, budget);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hi, tg;
    logic [N-1:0] pv;
    logic p0, ps;
    nCR = 1'b0; CE = 1'b1; SYNC = 1'b0;
    idle();
    bus3.WR_EN = 1'b0; bus3.WR_CH = '0; bus3.WR_DIV = '0; bus3.WR_CASC = 1'b0;

    // Reset values
    repeat (3) @(negedge CP);
    chk("rst_tick", 32'(TICK), 0);
    chk("rst_sqw",  32'(SQW), 0);
    chk("rst_pend", 32'(PEND), 0);
    chk("rst_ack",  32'(bus.WR_ACK), 0);
    chk("rst_err",  32'(bus.WR_ERR), 0);
    nCR = 1'b1;

    // Default ratio 50 on every channel, all in phase
    wait_tick(0, 200, n);
    chk("def_first_tick", n, 50);
    chk("def_all_ticks", 32'(TICK), 32'hF);
    n = 0; hi = 0;
    do begin @(negedge CP); n++; if (SQW[0]) hi++; end while (!TICK[0] && n < 200);
    chk("def_period", n, 50);
    chk("def_sqw_high", hi, 25);

    // Cascade: ch0 /5, ch1 /10 off ch0
    wr(0, 5, 1'b0); @(negedge CP);
    chk("ack_ch0", 32'(bus.WR_ACK), 1);
    wr(1, 10, 1'b1); @(negedge CP);
    chk("ack_ch1", 32'(bus.WR_ACK), 1);
    idle();
    chk("pend_01", 32'(PEND), 32'b0011);
    SYNC = 1'b1; @(negedge CP); SYNC = 1'b0;
    chk("sync_pend_clear", 32'(PEND), 0);
    chk("sync_no_tick", 32'(TICK), 0);
    wait_tick(1, 400, n);
    n = 0; hi = 0; p0 = 1'b0;
    do begin p0 = TICK[0]; @(negedge CP); n++; if (SQW[1]) hi++; end while (!TICK[1] && n < 400);
    chk("casc_period", n, 50);
    chk("casc_lag_parent_prev", 32'(p0), 1);
    chk("casc_lag_parent_now", 32'(TICK[0]), 0);
    chk("casc_sqw_high", hi, 25);

    // Glitch-free reload on ch2: /8 loaded with SYNC, /3 written at count 2
    wr(2, 8, 1'b0); SYNC = 1'b1; @(negedge CP); idle(); SYNC = 1'b0;
    chk("sync_wr_pend", 32'(PEND), 0);
    @(negedge CP); @(negedge CP);
    wr(2, 3, 1'b0); @(negedge CP); idle();
    chk("reload_pend_set", 32'(PEND[2]), 1);
    wait_tick(2, 50, n);
    chk("reload_old_period", 3 + n, 8);
    chk("reload_pend_clr", 32'(PEND[2]), 0);
    wait_tick(2, 50, n);
    chk("reload_new_period_a", n, 3);
    wait_tick(2, 50, n);
    chk("reload_new_period_b", n, 3);

    // Odd ratio 5: SQW high 3 of 5
    wr(3, 5, 1'b0); SYNC = 1'b1; @(negedge CP); idle(); SYNC = 1'b0;
    hi = 0;
    repeat (5) begin @(negedge CP); if (SQW[3]) hi++; end
    chk("div5_sqw_high", hi, 3);

    // Ratio 1: TICK and SQW continuously high
    wr(3, 1, 1'b0); SYNC = 1'b1; @(negedge CP); idle(); SYNC = 1'b0;
    n = 0; hi = 0;
    repeat (10) begin @(negedge CP); if (TICK[3]) n++; if (SQW[3]) hi++; end
    chk("div1_tick_high", n, 10);
    chk("div1_sqw_high", hi, 10);

    // Ratio 2: SQW toggles every advance
    wr(3, 2, 1'b0); SYNC = 1'b1; @(negedge CP); idle(); SYNC = 1'b0;
    @(negedge CP); ps = SQW[3]; tg = 0;
    repeat (8) begin @(negedge CP); if (SQW[3] != ps) tg++; ps = SQW[3]; end
    chk("div2_toggles", tg, 8);

    // Rejected writes: zero ratio, and an out-of-range channel on a 3-channel divider
    pv = PEND;
    wr(1, 0, 1'b1);
    bus3.WR_EN = 1'b1; bus3.WR_CH = 2'd3; bus3.WR_DIV = 16'd7;
    @(negedge CP); idle(); bus3.WR_EN = 1'b0;
    chk("err_div0", 32'(bus.WR_ERR), 1);
    chk("err_div0_noack", 32'(bus.WR_ACK), 0);
    chk("err_div0_pend", 32'(PEND), 32'(pv));
    chk("err_ch", 32'(bus3.WR_ERR), 1);
    chk("err_ch_noack", 32'(bus3.WR_ACK), 0);
    chk("err_ch_pend", 32'(PEND3), 0);
    wr(1, 10, 1'b1); @(negedge CP); idle();
    chk("valid_ack", 32'(bus.WR_ACK), 1);
    chk("valid_noerr", 32'(bus.WR_ERR), 0);
    @(negedge CP);
    chk("ack_one_cycle", 32'(bus.WR_ACK), 0);

    // Write landing on ch0's terminal advance loads at that wrap
    wait_tick(0, 50, n);
    repeat (4) @(negedge CP);
    wr(0, 7, 1'b0); @(negedge CP); idle();
    chk("term_wr_tick", 32'(TICK[0]), 1);
    chk("term_wr_pend", 32'(PEND[0]), 0);
    chk("term_wr_ack", 32'(bus.WR_ACK), 1);
    wait_tick(0, 50, n);
    chk("term_wr_period", n, 7);

    // CE low: writes accepted, reload stays pending, TICK quiet
    CE = 1'b0; wr(2, 4, 1'b0); @(negedge CP); idle();
    chk("ce0_ack", 32'(bus.WR_ACK), 1);
    repeat (20) @(negedge CP);
    chk("ce0_pend_hold", 32'(PEND[2]), 1);
    chk("ce0_tick", 32'(TICK), 0);

    // Asynchronous reset mid-period discards the pending write
    #2 nCR = 1'b0;
    #1;
    chk("amid_pend", 32'(PEND), 0);
    chk("amid_tick", 32'(TICK), 0);
    chk("amid_sqw", 32'(SQW), 0);
    @(negedge CP); nCR = 1'b1; CE = 1'b1;
    wait_tick(0, 200, n);
    chk("post_rst_period", n, 50);
    chk("post_rst_all", 32'(TICK), 32'hF);

    @(negedge CP);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
